// File: rtl/ex_mdu.sv
// RV32M multiply/divide unit: shared 32-iteration radix-2 shift-add / restoring-divide datapath.
// Optional MDU_FAST_MUL_EN: single-cycle 33x33 signed multiplier for MUL/MULH/MULHSU/MULHU.
module ex_mdu (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [31:0] OPERAND1,
  input  logic [31:0] OPERAND2,
  input  logic [4:0]  DEST,
  input  logic        KILL,
  output logic        BUSY,
  output logic [31:0] RESULT,
  output logic        RESULT_VALID,
  output logic [4:0]  RESULT_DEST
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DEST_W = 5;

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_REM = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [DEST_W-1:0]   dest_q;
  logic                neg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     hi_q;
  logic [XLEN-1:0]     lo_q;
  logic [XLEN-1:0]     b_q;
  logic [XLEN-1:0]     result_q;
  logic [DEST_W-1:0]   result_dest_q;

  // Request decode: operand signedness, magnitudes and the divide special cases
  logic            is_div, a_signed, b_signed, a_neg, b_neg, neg_req;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    is_div   = OP[2];
    a_signed = (OP == 3'd0) || (OP == 3'd1) || (OP == 3'd2) || (OP == OP_DIV) || (OP == OP_REM);
    b_signed = (OP == 3'd0) || (OP == 3'd1) || (OP == OP_DIV) || (OP == OP_REM);
    a_neg    = a_signed && OPERAND1[XLEN-1];
    b_neg    = b_signed && OPERAND2[XLEN-1];
    a_mag    = a_neg ? (XLEN'(0) - OPERAND1) : OPERAND1;
    b_mag    = b_neg ? (XLEN'(0) - OPERAND2) : OPERAND2;
    // remainder takes the dividend's sign; everything else the sign product
    neg_req  = (OP == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (OPERAND2 == XLEN'(0));
    div_ovf  = ((OP == OP_DIV) || (OP == OP_REM)) &&
               (OPERAND1 == 32'h8000_0000) && (OPERAND2 == 32'hFFFF_FFFF);
    special_res = '0;
    if (div_zero)     special_res = OP[1] ? OPERAND1 : 32'hFFFF_FFFF;
    else if (div_ovf) special_res = OP[1] ? 32'h0000_0000 : 32'h8000_0000;
  end

`ifdef MDU_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_p;
  logic        [XLEN-1:0]   fast_res;

  always_comb begin
    fast_a   = {a_signed && OPERAND1[XLEN-1], OPERAND1};
    fast_b   = {b_signed && OPERAND2[XLEN-1], OPERAND2};
    fast_p   = fast_a * fast_b;
    fast_res = (OP == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
  end
`endif

  // One datapath step plus the sign-corrected result of that step
  logic [XLEN:0]     mul_sum, div_trial;
  logic [XLEN-1:0]   hi_n, lo_n, dsel, dres, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : (XLEN+1)'(0));
    div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, b_q};
    if (op_q[2]) begin
      if (!div_trial[XLEN]) begin
        hi_n = div_trial[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod      = {hi_n, lo_n};
    prod_s    = neg_q ? ((2*XLEN)'(0) - prod) : prod;
    dsel      = op_q[1] ? hi_n : lo_n;
    dres      = neg_q ? (XLEN'(0) - dsel) : dsel;
    final_res = op_q[2] ? dres :
                ((op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= S_IDLE;
      op_q          <= '0;
      dest_q        <= '0;
      neg_q         <= 1'b0;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      b_q           <= '0;
      result_q      <= '0;
      result_dest_q <= '0;
    end else if (KILL) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            op_q   <= OP;
            dest_q <= DEST;
            neg_q  <= neg_req;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= is_div ? a_mag : b_mag;
            b_q    <= is_div ? b_mag : a_mag;
            if (div_zero || div_ovf) begin
              result_q      <= special_res;
              result_dest_q <= DEST;
              state         <= S_DONE;
`ifdef MDU_FAST_MUL_EN
            end else if (!is_div) begin
              result_q      <= fast_res;
              result_dest_q <= DEST;
              state         <= S_DONE;
`endif
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            result_q      <= final_res;
            result_dest_q <= dest_q;
            state         <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall must reach upstream in the request cycle itself, so BUSY is combinational
  assign BUSY         = !RESET && (((state == S_IDLE) && START && !KILL) || (state == S_CALC));
  assign RESULT_VALID = (state == S_DONE) && !KILL;
  assign RESULT       = result_q;
  assign RESULT_DEST  = result_dest_q;

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port START  input  1  request from ID/EX stage outputs to begin an M-extension operation.
REQ-004 SHALL have port OP  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have port OPERAND1  input  32  rs1 value (dividend/multiplicand).
REQ-006 SHALL have port OPERAND2  input  32  rs2 value (divisor/multiplier).
REQ-007 SHALL have port DEST  input  5  destination register address of the request.
REQ-008 SHALL have port KILL  input  1  flush from branch/exception logic; aborts any operation.
REQ-009 SHALL have port BUSY  output  1  stall request to the PC and IF/ID and ID/EX registers.
REQ-010 SHALL have port RESULT  output  32  operation result.
REQ-011 SHALL have port RESULT_VALID  output  1  one-cycle strobe; RESULT and RESULT_DEST are valid.
REQ-012 SHALL have port RESULT_DEST  output  5  destination register address captured at START.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL, in IDLE with START=1 and KILL=0, latch OP, OPERAND1, OPERAND2 and DEST at the rising edge; START in CALC or DONE is ignored.
REQ-015 SHALL, for divide/remainder and (without the configuration macro) for multiply, move IDLE->CALC, run exactly 32 radix-2 iterations (one per cycle, 5-bit counter 0..31), then move CALC->DONE.
REQ-016 SHALL assert RESULT_VALID only in DONE, for exactly one cycle, and return DONE->IDLE unconditionally.
REQ-017 SHALL give a latency of 33 cycles: START sampled at edge N puts the FSM in DONE after edge N+33.
REQ-018 SHALL drive BUSY = (IDLE and START and not KILL) or CALC, combinationally, so upstream registers hold from the request cycle; BUSY SHALL be 0 in DONE.
REQ-019 SHALL perform signed ops on the two's-complement magnitudes and sign-correct the result; MULHSU treats OPERAND1 as signed and OPERAND2 as unsigned.
REQ-020 SHALL return the low 32 bits of the 64-bit product for MUL and the high 32 bits for MULH/MULHSU/MULHU.
REQ-021 SHALL, on divide by zero, skip CALC (IDLE->DONE at edge N+1): DIV/DIVU give 0xFFFFFFFF; REM/REMU give OPERAND1.
REQ-022 SHALL, on DIV/REM with 0x80000000 / 0xFFFFFFFF, skip CALC: DIV gives 0x80000000; REM gives 0.
REQ-023 SHALL, when KILL=1 in any state, go to IDLE at the next edge with no RESULT_VALID; KILL in DONE suppresses RESULT_VALID that cycle.
REQ-024 SHALL hold RESULT and RESULT_DEST stable from DONE until the next DONE.

Reset
REQ-025 SHALL, on RESET=1 at a rising edge, enter IDLE and clear the counter, RESULT=0, RESULT_DEST=0, RESULT_VALID=0 and all latched operands.
REQ-026 SHALL give RESET priority over KILL and START; RESET mid-CALC aborts with no RESULT_VALID.
REQ-027 SHALL drive BUSY=0 while RESET=1.

Configuration
REQ-028 SHALL, with MDU_FAST_MUL_EN defined, compute all multiply ops with a single-cycle 33x33 signed multiplier: IDLE->DONE at edge N+1, RESULT_VALID in cycle N+1, BUSY high only in the request cycle.
REQ-029 SHALL, without MDU_FAST_MUL_EN, compute multiply by 32-iteration shift-add sharing the divider datapath, with the 33-cycle latency of REQ-017; results SHALL be identical in both builds.

Verification
REQ-030 SHALL cover: DIV 100 / 7 -> RESULT=14 after 33 cycles, RESULT_VALID for one cycle, BUSY high for 33 cycles.
REQ-031 SHALL cover: REM -100 (0xFFFFFF9C) / 7 -> RESULT=0xFFFFFFFE (-2); DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
REQ-032 SHALL cover: DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, both with RESULT_VALID one cycle after START.
REQ-033 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 SHALL cover: KILL at CALC cycle 10 -> IDLE next cycle, no RESULT_VALID, BUSY low; a new START is then accepted.
REQ-035 SHALL cover: MUL 3 * -4 with and without MDU_FAST_MUL_EN -> RESULT=0xFFFFFFF4 at latency 1 and 33 respectively; RESULT_DEST equals DEST captured at START.
